// File: rtl/pce_joyport_mux.sv
// PC Engine joypad-port front end: latches the CPU SEL/CLR writes, drives
// them to the MB128 save unit, steps the multitap pad index, and returns
// the 4-bit port nibble with the MB128 taking priority while it is active.
module pce_joyport_mux #(
    parameter int NUM_PADS = 5
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    cpu_wr,
    input  logic [1:0]              cpu_din,
    output logic [3:0]              cpu_dout,
    input  logic                    multitap_en,
    input  logic                    mb_enable,
    output logic                    mb_clk,
    output logic                    mb_data,
    input  logic                    mb_active,
    input  logic [3:0]              mb_dout,
    input  logic [8*NUM_PADS-1:0]   joy_in
);

    logic       port_sel_q, port_sel_d;
    logic       port_clr_q, port_clr_d;
    logic [2:0] pad_idx_q, pad_idx_d;
    logic       mb_active_prev_q;
    logic [3:0] cpu_dout_q, cpu_dout_d;

    logic       mb_intercept;
    logic       mb_session_end;

    // Per-index nibbles, already inverted to the active-low port format.
    // Indices with no pad behind them are tied off, so any pad_idx value
    // selects a defined entry and never reaches outside joy_in.
    logic [3:0] dir_nib [0:7];
    logic [3:0] btn_nib [0:7];

    for (genvar gi = 0; gi < 8; gi++) begin : g_pad_nib
        if (gi < NUM_PADS) begin : g_present
            assign dir_nib[gi] = ~joy_in[8*gi +: 4];
            assign btn_nib[gi] = ~joy_in[8*gi+4 +: 4];
        end else begin : g_absent
            assign dir_nib[gi] = 4'h0;
            assign btn_nib[gi] = 4'h0;
        end
    end

    assign mb_intercept   = mb_enable & mb_active;
    // The session end is seen regardless of mb_enable so a stale index
    // never survives an MB128 transaction.
    assign mb_session_end = mb_active_prev_q & ~mb_active;

    assign mb_data = port_sel_q;
    assign mb_clk  = port_clr_q;

    // Next state for the SEL/CLR latch and the multitap pad index.
    always_comb begin
        port_sel_d = port_sel_q;
        port_clr_d = port_clr_q;
        pad_idx_d  = pad_idx_q;
        if (cpu_wr) begin
            port_sel_d = cpu_din[0];
            port_clr_d = cpu_din[1];
        end
        if (mb_session_end) begin
            pad_idx_d = 3'd0;
        end else if (cpu_wr) begin
            if (!multitap_en) begin
                pad_idx_d = 3'd0;
            end else if (mb_intercept) begin
                pad_idx_d = pad_idx_q;
            end else if (cpu_din[1]) begin
                pad_idx_d = 3'd0;
            end else if (!port_sel_q && cpu_din[0]) begin
                // Saturate rather than wrap so extra SEL pulses keep
                // reading an absent pad instead of cycling back to pad 0.
                if (pad_idx_q != 3'd7) begin
                    pad_idx_d = pad_idx_q + 3'd1;
                end
            end
        end
    end

    // Port read nibble, computed from the current registers and inputs.
    always_comb begin
        cpu_dout_d = 4'h0;
        if (port_clr_q) begin
            cpu_dout_d = 4'h0;
        end else if (mb_intercept) begin
            cpu_dout_d = mb_dout;
        end else if (int'(pad_idx_q) >= NUM_PADS) begin
            cpu_dout_d = 4'h0;
        end else if (port_sel_q) begin
            cpu_dout_d = dir_nib[pad_idx_q];
        end else begin
            cpu_dout_d = btn_nib[pad_idx_q];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            port_sel_q       <= 1'b0;
            port_clr_q       <= 1'b0;
            pad_idx_q        <= 3'd0;
            mb_active_prev_q <= 1'b0;
            cpu_dout_q       <= 4'h0;
        end else begin
            port_sel_q       <= port_sel_d;
            port_clr_q       <= port_clr_d;
            pad_idx_q        <= pad_idx_d;
            mb_active_prev_q <= mb_active;
            cpu_dout_q       <= cpu_dout_d;
        end
    end

    assign cpu_dout = cpu_dout_q;

endmodule

// File: tb/tb_pce_joyport_mux.sv
// Directed bench for pce_joyport_mux with hand-computed expected nibbles.
module tb_pce_joyport_mux;

    localparam int NP = 5;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            cpu_wr;
    logic [1:0]      cpu_din;
    logic [3:0]      cpu_dout;
    logic            multitap_en;
    logic            mb_enable;
    logic            mb_clk;
    logic            mb_data;
    logic            mb_active;
    logic [3:0]      mb_dout;
    logic [8*NP-1:0] joy_in;

    int n_checks = 0;
    int n_errors = 0;

    pce_joyport_mux #(.NUM_PADS(NP)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .cpu_wr      (cpu_wr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .multitap_en (multitap_en),
        .mb_enable   (mb_enable),
        .mb_clk      (mb_clk),
        .mb_data     (mb_data),
        .mb_active   (mb_active),
        .mb_dout     (mb_dout),
        .joy_in      (joy_in)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One-cycle write strobe; returns on the falling edge after the latch edge.
    task automatic do_write(input logic clr, input logic sel);
        @(negedge clk_sys);
        cpu_wr  = 1'b1;
        cpu_din = {clr, sel};
        @(negedge clk_sys);
        cpu_wr  = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        cpu_wr      = 1'b0;
        cpu_din     = 2'b00;
        multitap_en = 1'b0;
        mb_enable   = 1'b0;
        mb_active   = 1'b0;
        mb_dout     = 4'h0;
        joy_in      = '0;

        // Reset state
        repeat (2) @(negedge clk_sys);
        check("rst_dout", cpu_dout, 4'h0);
        check("rst_mbclk", {3'b0, mb_clk}, 4'h0);
        check("rst_mbdata", {3'b0, mb_data}, 4'h0);
        reset = 1'b0;
        @(negedge clk_sys);
        check("idle_pad0_btn", cpu_dout, 4'hF);

        // 1: single pad, SEL=1, up pressed
        joy_in[0] = 1'b1;
        do_write(1'b0, 1'b1);
        check("t1_mbdata", {3'b0, mb_data}, 4'h1);
        check("t1_mbclk", {3'b0, mb_clk}, 4'h0);
        @(negedge clk_sys);
        check("t1_dout", cpu_dout, 4'hE);

        // 2: multitap sequence to pad 3, run pressed
        multitap_en = 1'b1;
        joy_in      = '0;
        joy_in[31]  = 1'b1;
        do_write(1'b1, 1'b0);
        check("t2_mbclk", {3'b0, mb_clk}, 4'h1);
        @(negedge clk_sys);
        check("t2_clr_dout", cpu_dout, 4'h0);
        do_write(1'b0, 1'b0);
        @(negedge clk_sys);
        check("t2_pad0_btn", cpu_dout, 4'hF);
        for (int i = 0; i < 3; i++) begin
            do_write(1'b0, 1'b1);
            do_write(1'b0, 1'b0);
        end
        @(negedge clk_sys);
        check("t2_pad3_btn", cpu_dout, 4'h7);

        // 3: saturate at index 7 (absent pad)
        joy_in = '0;
        for (int i = 0; i < 6; i++) begin
            do_write(1'b0, 1'b1);
            do_write(1'b0, 1'b0);
        end
        @(negedge clk_sys);
        check("t3_sat_sel0", cpu_dout, 4'h0);
        do_write(1'b0, 1'b1);
        @(negedge clk_sys);
        check("t3_sat_sel1", cpu_dout, 4'h0);

        // 4: MB128 intercept, then session end on a SEL-rising write
        joy_in[0] = 1'b1;
        mb_enable = 1'b1;
        mb_active = 1'b1;
        mb_dout   = 4'h4;
        @(negedge clk_sys);
        do_write(1'b0, 1'b0);
        do_write(1'b0, 1'b1);
        do_write(1'b0, 1'b0);
        do_write(1'b0, 1'b1);
        @(negedge clk_sys);
        check("t4_mb_dout", cpu_dout, 4'h4);
        do_write(1'b0, 1'b0);
        @(negedge clk_sys);
        cpu_wr    = 1'b1;
        cpu_din   = 2'b01;
        mb_active = 1'b0;
        @(negedge clk_sys);
        cpu_wr    = 1'b0;
        check("t4_mbdata", {3'b0, mb_data}, 4'h1);
        @(negedge clk_sys);
        check("t4_end_pad0", cpu_dout, 4'hE);

        // 5: no multitap, MB128 disabled but reporting active
        multitap_en = 1'b0;
        mb_enable   = 1'b0;
        mb_active   = 1'b1;
        mb_dout     = 4'h4;
        joy_in      = '0;
        joy_in[7:0] = 8'h81;
        do_write(1'b0, 1'b0);
        @(negedge clk_sys);
        check("t5_pad0_btn_a", cpu_dout, 4'h7);
        do_write(1'b0, 1'b1);
        @(negedge clk_sys);
        check("t5_pad0_dir_a", cpu_dout, 4'hE);
        do_write(1'b0, 1'b0);
        do_write(1'b0, 1'b1);
        @(negedge clk_sys);
        check("t5_pad0_dir_b", cpu_dout, 4'hE);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        check("t5_arst_dout", cpu_dout, 4'h0);
        check("t5_arst_mbdata", {3'b0, mb_data}, 4'h0);
        check("t5_arst_mbclk", {3'b0, mb_clk}, 4'h0);
        @(negedge clk_sys);
        reset = 1'b0;
        check("t5_rel_dout", cpu_dout, 4'h0);
        @(negedge clk_sys);
        check("t5_post_pad0", cpu_dout, 4'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pce_joyport_mux.md
Name: pce_joyport_mux

Overview:
- Joypad-port front end between the CPU I/O write/read path and all devices on the PC Engine controller port: MB128 save unit, multitap, and up to five pads.
- Latches the CPU-written SEL/CLR lines and drives them to the MB128 clock/data inputs.
- Runs the multitap pad-index sequencer.
- Returns the 4-bit port nibble, giving the MB128 priority whenever its protocol is active.

Parameters:
NUM_PADS, 5, number of pads on the multitap (1..7); indices at or above this read as absent.

Ports:
clk_sys  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_wr  in  1  one-cycle strobe for a CPU write to the joypad port.
cpu_din  in  2  write data: [0]=SEL, [1]=CLR.
cpu_dout  out  4  registered port-read nibble (active-low pad data).
multitap_en  in  1  1 = multitap attached, 0 = single pad on index 0.
mb_enable  in  1  1 = MB128 attached.
mb_clk  out  1  to MB128 clock input; equals latched CLR.
mb_data  out  1  to MB128 data input; equals latched SEL.
mb_active  in  1  MB128 protocol-active flag.
mb_dout  in  4  MB128 return nibble.
joy_in  in  8*NUM_PADS  pad N occupies bits [8N+7:8N].
- Pad bit order: [0]up [1]right [2]down [3]left [4]I [5]II [6]select [7]run.
- Active-high pressed.

Behaviour:
- Reset (async) values: port_sel=0, port_clr=0, pad_idx=0, mb_active_prev=0, cpu_dout=4'h0, mb_clk=0, mb_data=0.
- Port latch: on a clk_sys edge with cpu_wr=1, port_sel<=cpu_din[0] and port_clr<=cpu_din[1]. mb_data=port_sel and mb_clk=port_clr, both driven straight from the registers.
- MB128 intercept: mb_intercept = mb_enable & mb_active.
- pad_idx: 3-bit register, evaluated only on a cpu_wr edge, using the old port_sel and the new cpu_din. Conditions in priority order:
  1. mb_active_prev=1 and mb_active=0 (MB128 session ended; tracked every cycle, independent of cpu_wr) -> pad_idx<=0. This wins over any simultaneous write.
  2. multitap_en=0 -> pad_idx<=0.
  3. mb_intercept=1 -> hold (the MB128 swallows the traffic).
  4. cpu_din[1]=1 -> pad_idx<=0.
  5. port_sel=0 and cpu_din[0]=1 -> pad_idx<=pad_idx+1, saturating at 7 (no wrap).
  6. Otherwise -> hold.
- mb_active_prev<=mb_active every cycle.
- cpu_dout: registered every cycle from the current registers and inputs, so it reflects a write one cycle after the cpu_wr edge. Priority:
  1. port_clr=1 -> 4'h0.
  2. mb_intercept -> mb_dout.
  3. pad_idx>=NUM_PADS -> 4'h0 (absent pad).
  4. port_sel=1 -> ~joy_in[8*pad_idx+3 : 8*pad_idx] (directions).
  5. port_sel=0 -> ~joy_in[8*pad_idx+7 : 8*pad_idx+4] (buttons).
- pad_idx beyond NUM_PADS-1 must never index outside joy_in.
- Idle/released pad reads 4'hF.
- mb_enable=0 ignores mb_active/mb_dout entirely for data selection. mb_clk/mb_data are still driven, and the session-end reset still applies.
- Reset mid-sequence: all state clears immediately; the next read returns 4'h0 until the clock edge after reset release, then pad 0 data.

Test Plan:
1. After reset, no write: cpu_dout=4'h0. Write {CLR=0,SEL=1} with pad0 up pressed (joy_in[0]=1) -> cpu_dout=4'hE one cycle later; mb_data=1, mb_clk=0.
2. multitap_en=1, NUM_PADS=5. Write CLR=1, then CLR=0/SEL=0, then SEL toggled 0->1 three times with pad3 run pressed. On SEL=0 -> cpu_dout=4'h7; pad_idx=3.
3. Six further SEL rising writes -> pad_idx saturates at 7 and cpu_dout=4'h0 for both SEL values.
4. mb_enable=1, mb_active=1, mb_dout=4'h4: writes with SEL rising leave pad_idx unchanged and cpu_dout=4'h4. Drop mb_active on the same edge as a SEL-rising write -> pad_idx=0.
5. multitap_en=0: repeated SEL rising writes keep pad_idx=0 and cpu_dout tracks pad0 only. Assert reset mid-stream -> outputs 0 asynchronously.
